// File: rtl/chunked_seq_adder.sv
// Multi-cycle add/sub: one CHUNK-bit ripple slice per clock, done pulses WIDTH/CHUNK cycles after an accepted start.
// start is only sampled while idle; requests arriving during a run are dropped, not queued.
module chunked_seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
            $error("chunked_seq_adder: illegal WIDTH/CHUNK combination");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    int               base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] sum;
    logic             c_out;
    logic             c_msb;
    logic [WIDTH-1:0] res_next;
    logic             last;

    always_comb begin
        base     = int'(cnt) * CHUNK;
        a_chunk  = op_a[base +: CHUNK];
        b_chunk  = op_b[base +: CHUNK];
        {c_out, sum} = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry);
        // Carry into the slice MSB recovered from the sum bit, valid for any CHUNK.
        c_msb    = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum[CHUNK-1];
        res_next = acc;
        res_next[base +: CHUNK] = sum;
        last     = (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= res_next;
                    carry <= c_out;
                    if (last) begin
                        // Outputs only change here, so partial sums never escape.
                        s     <= res_next;
                        cout  <= c_out;
                        ovf   <= c_msb ^ c_out;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
